fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-counter and fetch controller for the team's 8-bit processor. It is the consumer side of the branch-target LUT. It drives the 4-bit LUT index taken from the current branch instruction, samples the 8-bit absolute target the LUT returns, and sequences the PC through run, branch, stall and halt. It sits between the decode stage (branch/halt/stall controls) and instruction memory (PC out), and it tells the testbench when a program has finished.

## Interface

Parameters:
- PC_W, 8: PC and LUT target width
- IDX_W, 4: LUT index width
- CNT_W, 8: taken-branch counter width

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset (asserted when 0, sampled on Clk rising edge)
- Start  in  1  one-cycle pulse; begin execution at StartAddr
- StartAddr  in  PC_W  program entry address
- Stall  in  1  hold current instruction; no retirement this cycle
- Halt  in  1  current instruction is halt
- BranchEn  in  1  current instruction is a LUT branch
- Taken  in  1  branch condition result; meaningful only when BranchEn=1
- LutIdx  in  IDX_W  branch target index field from the instruction
- LutAddr  out  IDX_W  index driven to the LUT
- LutTarget  in  PC_W  absolute target returned by the LUT (combinational)
- PC  out  PC_W  current instruction address
- Running  out  1  high while in RUN
- Done  out  1  high while in HALTED
- BranchCount  out  CNT_W  taken branches since last Start, saturating

## Operation

- **State machine:** IDLE, RUN, HALTED.
  - IDLE → RUN on Start.
  - RUN → HALTED on a retired Halt.
  - HALTED → RUN on Start.
  - Start in RUN restarts execution: PC←StartAddr, BranchCount←0, stay in RUN.
- **Start, any state:** PC←StartAddr, BranchCount←0, Done←0. Start has top priority over Stall, Halt and BranchEn.
- **RUN, retirement:** an instruction retires when Stall=0. Priority among retiring events:
  1. Halt: PC holds, next state HALTED.
  2. BranchEn & Taken: PC←LutTarget, BranchCount+1 (saturates at 2^CNT_W−1, no wrap).
  3. Otherwise: PC←PC+1, modulo 2^PC_W (255→0).
- **Halt with BranchEn=1 and Taken=1:** halt wins, no branch is taken, and BranchCount does not change.
- **Stall=1 in RUN:** PC, state and BranchCount hold. Halt and branch are ignored that cycle.
- **IDLE and HALTED:** PC and BranchCount hold. Stall, Halt and BranchEn are ignored.
- **LutAddr:** equals LutIdx combinationally in all states. The LUT is combinational, so no extra register is needed.
- **Taken with BranchEn=0:** ignored.

## Timing

- **Reset=0 at a rising edge:**
  - State=IDLE
  - PC=0
  - Running=0
  - Done=0
  - BranchCount=0
  - Reset overrides Start and all other inputs.
- **Reset mid-RUN:** returns to IDLE with all outputs at reset values on the next edge. Start is required to resume.
- **Start latency:** Start sampled at edge N gives PC=StartAddr and Running=1 after edge N.
- **Branch latency:** the branch decision and LutTarget are sampled at edge N, and PC=LutTarget after edge N. There is no delay slot and no bubble.
- **Halt latency:** Halt sampled at edge N gives Done=1 and Running=0 after edge N. PC stays at the halt instruction's address.
- **Output registration:** Running, Done, PC and BranchCount are registered. LutAddr is the only combinational output.
- **Start during HALTED:** Done drops on the same edge at which PC loads StartAddr.

## Test plan

- **Reset then start:** hold Reset=0 for 2 cycles, then release.
  - Required: PC=0, Running=0, Done=0, BranchCount=0.
  - Then Start with StartAddr=0, run 3 cycles with no controls. Required: PC=1, 2, 3 and Running=1.
- **Taken branch:** with the team's branch LUT attached, BranchEn=1, Taken=1, LutIdx=4'b0010.
  - Required: LutAddr=2 the same cycle, PC=235 the next cycle, BranchCount=1.
  - Repeat with Taken=0 from PC=10. Required: PC=11 and BranchCount unchanged.
- **Wrap and stall:** StartAddr=254, run 2 cycles. Required: PC=255, then 0.
  - Assert Stall=1 with BranchEn=1, Taken=1 for 3 cycles. Required: PC holds at 0 and BranchCount holds.
- **Halt priority:** at PC=20 assert Halt=1, BranchEn=1, Taken=1, LutIdx=3.
  - Required: the next cycle PC=20, Done=1, Running=0, BranchCount unchanged.
  - Later BranchEn pulses: required no change.
- **Restart and counter saturation:**
  - In HALTED, Start with StartAddr=4. Required: PC=4, Done=0, BranchCount=0.
  - Force 300 taken branches (LutIdx=7). Required: BranchCount=255, not wrapped.
- **Reset mid-run and Start-over-stall:**
  - Reset=0 while PC=100 in RUN. Required: PC=0 and IDLE the next cycle.
  - Start with Stall=1 and StartAddr=129. Required: PC=129 and Running=1.

Source files
------------

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - PC and fetch sequencer driving the branch-target LUT
module fetch_ctrl #(
    parameter int PC_W  = 8,
    parameter int IDX_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic [IDX_W-1:0] LutIdx,
    output logic [IDX_W-1:0] LutAddr,
    input  logic [PC_W-1:0]  LutTarget,
    output logic [PC_W-1:0]  PC,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] BranchCount
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, done_q;

    assign LutAddr     = LutIdx;
    assign PC          = pc_q;
    assign Running     = running_q;
    assign Done        = done_q;
    assign BranchCount = cnt_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_HALTED);
        end
    end

    // Start beats everything; otherwise only a non-stalled RUN cycle retires.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (Start) begin
            state_d = S_RUN;
            pc_d    = StartAddr;
            cnt_d   = '0;
        end else if (state_q == S_RUN && !Stall) begin
            if (Halt) begin
                state_d = S_HALTED;
            end else if (BranchEn && Taken) begin
                pc_d = LutTarget;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized and directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic [7:0] StartAddr = 8'd0;
    logic       Stall = 1'b0;
    logic       Halt = 1'b0;
    logic       BranchEn = 1'b0;
    logic       Taken = 1'b0;
    logic [3:0] LutIdx = 4'd0;
    logic [3:0] LutAddr;
    logic [7:0] LutTarget;
    logic [7:0] PC;
    logic       Running;
    logic       Done;
    logic [7:0] BranchCount;

    logic [7:0] lut [16];

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Reference state: mode 0 = idle, 1 = running, 2 = finished
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;

    fetch_ctrl #(.PC_W(8), .IDX_W(4), .CNT_W(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Halt(Halt), .BranchEn(BranchEn), .Taken(Taken),
        .LutIdx(LutIdx), .LutAddr(LutAddr), .LutTarget(LutTarget),
        .PC(PC), .Running(Running), .Done(Done), .BranchCount(BranchCount)
    );

    always #5 Clk = ~Clk;

    assign LutTarget = lut[LutAddr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge Clk) begin
        if (!Reset) begin
            m_mode <= 0;
            m_pc   <= 0;
            m_cnt  <= 0;
        end else if (Start) begin
            m_mode <= 1;
            m_pc   <= int'(StartAddr);
            m_cnt  <= 0;
        end else if (m_mode == 1 && !Stall) begin
            if (Halt) m_mode <= 2;
            else if (BranchEn && Taken) begin
                m_pc  <= int'(lut[LutIdx]);
                m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
            end else begin
                m_pc <= (m_pc + 1) % 256;
            end
        end
    end

    always @(negedge Clk) begin
        if (check_en) begin
            chk("model_pc", int'(PC), m_pc);
            chk("model_running", int'(Running), int'(m_mode == 1));
            chk("model_done", int'(Done), int'(m_mode == 2));
            chk("model_count", int'(BranchCount), m_cnt);
            chk("model_lutaddr", int'(LutAddr), int'(LutIdx));
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_at(input logic [7:0] addr);
        Start = 1'b1;
        StartAddr = addr;
        cyc();
        Start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) lut[i] = 8'((i * 37 + 11) & 255);
        lut[2] = 8'd235;
        lut[7] = 8'd70;

        // reset then start
        cyc();
        check_en = 1'b1;
        cyc();
        chk("reset_pc", int'(PC), 0);
        chk("reset_running", int'(Running), 0);
        chk("reset_done", int'(Done), 0);
        chk("reset_count", int'(BranchCount), 0);
        Reset = 1'b1;
        start_at(8'd0);
        chk("start_pc", int'(PC), 0);
        chk("start_running", int'(Running), 1);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            chk("seq_pc", int'(PC), i);
        end

        // taken branch through the LUT
        BranchEn = 1'b1; Taken = 1'b1; LutIdx = 4'b0010;
        #1;
        chk("lutaddr_comb", int'(LutAddr), 2);
        cyc();
        chk("branch_pc", int'(PC), 235);
        chk("branch_count", int'(BranchCount), 1);
        BranchEn = 1'b0; Taken = 1'b0;

        // not-taken branch
        start_at(8'd10);
        BranchEn = 1'b1; Taken = 1'b0; LutIdx = 4'd2;
        cyc();
        chk("nottaken_pc", int'(PC), 11);
        chk("nottaken_count", int'(BranchCount), 0);
        BranchEn = 1'b0;

        // wrap and stall
        start_at(8'd254);
        cyc();
        chk("wrap_pc255", int'(PC), 255);
        cyc();
        chk("wrap_pc0", int'(PC), 0);
        Stall = 1'b1; BranchEn = 1'b1; Taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_pc", int'(PC), 0);
            chk("stall_count", int'(BranchCount), 0);
        end
        Stall = 1'b0; BranchEn = 1'b0; Taken = 1'b0;

        // halt priority over branch
        start_at(8'd20);
        Halt = 1'b1; BranchEn = 1'b1; Taken = 1'b1; LutIdx = 4'd3;
        cyc();
        chk("halt_pc", int'(PC), 20);
        chk("halt_done", int'(Done), 1);
        chk("halt_running", int'(Running), 0);
        chk("halt_count", int'(BranchCount), 0);
        Halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            BranchEn = 1'b1; Taken = 1'b1;
            cyc();
            BranchEn = 1'b0; Taken = 1'b0;
            cyc();
            chk("halted_pc", int'(PC), 20);
            chk("halted_done", int'(Done), 1);
        end

        // restart and saturation
        start_at(8'd4);
        chk("restart_pc", int'(PC), 4);
        chk("restart_done", int'(Done), 0);
        chk("restart_count", int'(BranchCount), 0);
        BranchEn = 1'b1; Taken = 1'b1; LutIdx = 4'd7;
        for (int i = 0; i < 300; i++) cyc();
        chk("sat_count", int'(BranchCount), 255);
        chk("sat_pc", int'(PC), 70);
        BranchEn = 1'b0; Taken = 1'b0;

        // reset mid-run, then start over a stall
        start_at(8'd100);
        chk("pre_reset_pc", int'(PC), 100);
        Reset = 1'b0;
        cyc();
        chk("midreset_pc", int'(PC), 0);
        chk("midreset_running", int'(Running), 0);
        Reset = 1'b1;
        Stall = 1'b1;
        start_at(8'd129);
        chk("startstall_pc", int'(PC), 129);
        chk("startstall_running", int'(Running), 1);
        Stall = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            Reset     = ($urandom % 64) != 0;
            Start     = ($urandom % 32) == 0;
            StartAddr = 8'($urandom);
            Stall     = ($urandom % 4) == 0;
            Halt      = ($urandom % 24) == 0;
            BranchEn  = 1'($urandom);
            Taken     = 1'($urandom);
            LutIdx    = 4'($urandom);
            cyc();
        end

        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; Halt = 1'b0; BranchEn = 1'b0;
        cyc();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
